// File: rtl/tc_event_timer.sv
// Purpose : counts terminal-count events from an external ripple counter and
//           flags expiry after a programmed number of events (one-shot or periodic).
// Latency : tc_in rise sampled at edge k -> tc_evt at k+SYNC_STAGES -> ev_cnt/irq at k+SYNC_STAGES+1.
// Backpressure: none; start is ignored while busy, stop aborts to IDLE.
// Ports: clk/clr (async active-low); tc_in (async); start/stop/mode/period (control);
//        cnt_rst_b (upstream counter clear), busy, expired (sticky), irq (1-cycle), ev_cnt.
module tc_event_timer #(
    parameter int CNT_W       = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             tc_in,
    input  logic             start,
    input  logic             stop,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    output logic             cnt_rst_b,
    output logic             busy,
    output logic             expired,
    output logic             irq,
    output logic [CNT_W-1:0] ev_cnt
);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARM  = 2'd1,
        ST_RUN  = 2'd2,
        ST_DONE = 2'd3
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    // Marks which synchronizer stages hold a sample taken after reset release,
    // so a tc_in already high at release is not mistaken for a rising edge.
    logic [SYNC_STAGES-1:0] vld_q, vld_d;
    logic                   prev_q, prev_d;
    logic                   prev_vld_q, prev_vld_d;
    logic                   tc_evt_q, tc_evt_d;

    logic [CNT_W-1:0]       per_q, per_d;
    logic                   mode_q, mode_d;
    logic [CNT_W-1:0]       ev_cnt_q, ev_cnt_d;
    logic                   expired_q, expired_d;
    logic                   irq_q, irq_d;
    logic                   busy_q, busy_d;
    logic                   cnt_rst_b_q, cnt_rst_b_d;

    // One bit wider than the counter so the compare never wraps.
    logic [CNT_W:0]         cnt_inc;

    // Synchronizer and registered rising-edge detector.
    always_comb begin
        sync_d     = {sync_q[SYNC_STAGES-2:0], tc_in};
        vld_d      = {vld_q[SYNC_STAGES-2:0], 1'b1};
        prev_d     = sync_q[SYNC_STAGES-1];
        prev_vld_d = vld_q[SYNC_STAGES-1];
        tc_evt_d   = sync_q[SYNC_STAGES-1] & ~prev_q & prev_vld_q;
        // Entering a new run: drop any pending edge and treat the current level
        // as already seen, so only a fresh rise after ARM is counted.
        if (state_q == ST_ARM) begin
            tc_evt_d = 1'b0;
            prev_d   = 1'b1;
        end
    end

    // FSM next state and registered outputs.
    always_comb begin
        state_d   = state_q;
        per_d     = per_q;
        mode_d    = mode_q;
        ev_cnt_d  = ev_cnt_q;
        expired_d = expired_q;
        irq_d     = 1'b0;
        cnt_inc   = {1'b0, ev_cnt_q} + {{CNT_W{1'b0}}, 1'b1};

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start && (period != '0)) begin
                    state_d   = ST_ARM;
                    per_d     = period;
                    mode_d    = mode;
                    ev_cnt_d  = '0;
                    expired_d = 1'b0;
                end
            end
            ST_ARM: begin
                state_d = stop ? ST_IDLE : ST_RUN;
            end
            ST_RUN: begin
                // stop wins over a coincident event: it is neither counted nor expires.
                if (stop) begin
                    state_d = ST_IDLE;
                end else if (tc_evt_q) begin
                    if (cnt_inc < {1'b0, per_q}) begin
                        ev_cnt_d = cnt_inc[CNT_W-1:0];
                    end else begin
                        ev_cnt_d  = '0;
                        irq_d     = 1'b1;
                        expired_d = 1'b1;
                        if (!mode_q) begin
                            state_d = ST_DONE;
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // Decoded from the next state so these registers line up with state_q.
        busy_d      = (state_d == ST_ARM) || (state_d == ST_RUN);
        cnt_rst_b_d = busy_d;
    end

    always_ff @(posedge clk or negedge clr) begin
        if (!clr) begin
            state_q     <= ST_IDLE;
            sync_q      <= '0;
            vld_q       <= '0;
            prev_q      <= 1'b0;
            prev_vld_q  <= 1'b0;
            tc_evt_q    <= 1'b0;
            per_q       <= '0;
            mode_q      <= 1'b0;
            ev_cnt_q    <= '0;
            expired_q   <= 1'b0;
            irq_q       <= 1'b0;
            busy_q      <= 1'b0;
            cnt_rst_b_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sync_q      <= sync_d;
            vld_q       <= vld_d;
            prev_q      <= prev_d;
            prev_vld_q  <= prev_vld_d;
            tc_evt_q    <= tc_evt_d;
            per_q       <= per_d;
            mode_q      <= mode_d;
            ev_cnt_q    <= ev_cnt_d;
            expired_q   <= expired_d;
            irq_q       <= irq_d;
            busy_q      <= busy_d;
            cnt_rst_b_q <= cnt_rst_b_d;
        end
    end

    assign cnt_rst_b = cnt_rst_b_q;
    assign busy      = busy_q;
    assign expired   = expired_q;
    assign irq       = irq_q;
    assign ev_cnt    = ev_cnt_q;

endmodule

// File: doc/tc_event_timer.md
TC_EVENT_TIMER -- requirements
Module: tc_event_timer

Interface
REQ-001 SHALL have parameter CNT_W, default 8, width of the period register and the event count.
REQ-002 SHALL have parameter SYNC_STAGES, default 2, number of synchronizer flops on tc_in (minimum 2).
REQ-003 SHALL have port clk, input, 1, single system clock; all state is updated on its rising edge.
REQ-004 SHALL have port clr, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port tc_in, input, 1, terminal count from the upstream 4-bit ripple counter; asynchronous to clk.
REQ-006 SHALL have port start, input, 1, start request, level-sampled each clk.
REQ-007 SHALL have port stop, input, 1, abort request, level-sampled each clk.
REQ-008 SHALL have port mode, input, 1, 0 = one-shot, 1 = periodic; sampled at start.
REQ-009 SHALL have port period, input, CNT_W, number of tc events per expiry; sampled at start.
REQ-010 SHALL have port cnt_rst_b, output, 1, active-low clear driven to the upstream counter's clr.
REQ-011 SHALL have port busy, output, 1, high in ARM and RUN.
REQ-012 SHALL have port expired, output, 1, sticky expiry flag.
REQ-013 SHALL have port irq, output, 1, one-cycle expiry pulse.
REQ-014 SHALL have port ev_cnt, output, CNT_W, tc events counted in the current period.

Function
REQ-015 SHALL pass tc_in through SYNC_STAGES flops, then a registered rising-edge detector producing tc_evt.
- Edge k: first sample of tc_in high.
- Edge k+SYNC_STAGES: tc_evt asserts.
REQ-016 SHALL count a tc_in high level of any length as exactly one event; upstream guarantees high and low widths of at least 2 clk periods.
REQ-017 SHALL implement states IDLE, ARM, RUN and DONE, encoded in a registered FSM.
REQ-018 SHALL behave as follows in IDLE:
- cnt_rst_b=0, busy=0.
- start with period!=0: latch period/mode, clear ev_cnt, clear expired, go to ARM.
- start with period==0: ignored, stay in IDLE.
REQ-019 SHALL behave as follows in ARM:
- cnt_rst_b=1, busy=1.
- Clear the edge-detector history so no stale edge is counted.
- Go to RUN on the next edge.
REQ-020 SHALL behave as follows in RUN:
- cnt_rst_b=1, busy=1.
- On tc_evt with ev_cnt+1 < latched period: increment ev_cnt.
REQ-021 SHALL handle expiry in RUN, i.e. tc_evt with ev_cnt+1 == latched period:
- irq=1 for exactly one cycle and expired=1, both on the same edge.
- mode=1: ev_cnt=0, stay in RUN.
- mode=0: go to DONE, ev_cnt=0.
REQ-022 SHALL behave as follows in DONE:
- cnt_rst_b=0, busy=0, expired held at 1.
- start (period!=0): go to ARM and clear expired.
REQ-023 SHALL, on stop in ARM or RUN, go to IDLE on the next edge with cnt_rst_b=0, ev_cnt held and expired unchanged.
REQ-024 SHALL give stop priority over start and over a coincident tc_evt; that event is not counted and no irq fires.
REQ-025 SHALL ignore start while in ARM or RUN.
REQ-026 SHALL ignore changes to period and mode while busy.
REQ-027 SHALL keep ev_cnt within 0..period-1; ev_cnt never wraps through 2^CNT_W.
REQ-028 SHALL drive all outputs directly from registers, with no combinational path from inputs to outputs.

Reset
REQ-029 SHALL, while clr=0, asynchronously force the following, independent of clk:
- state=IDLE.
- All synchronizer and edge flops=0.
- cnt_rst_b=0, busy=0, expired=0, irq=0, ev_cnt=0.
REQ-030 SHALL abort an operation in progress immediately when clr falls mid-operation, with no irq, and resume in IDLE after clr rises.
REQ-031 SHALL NOT register an event from a tc_in already high at reset release until tc_in falls and rises again.

Verification
REQ-032 SHALL cover reset mid-RUN: pulse clr low during RUN with ev_cnt=2 -> all outputs 0 before the next clk edge; the bench stays in IDLE until start.
REQ-033 SHALL cover one-shot expiry: mode=0, period=3, start, three tc_in pulses -> ev_cnt steps 1,2; irq is high for one cycle SYNC_STAGES+1 edges after the third rise is sampled; then expired=1, busy=0, cnt_rst_b=0.
REQ-034 SHALL cover periodic mode: mode=1, period=2, six tc_in pulses -> exactly 3 irq pulses; ev_cnt sequence 1,0,1,0,1,0; busy stays 1.
REQ-035 SHALL cover stop colliding with an event: stop asserted in the same cycle as tc_evt with ev_cnt=1 -> IDLE, ev_cnt=1, no irq, cnt_rst_b=0.
REQ-036 SHALL cover illegal start: period=0, start -> state stays IDLE, busy=0, cnt_rst_b=0.
REQ-037 SHALL cover long tc_in high: tc_in held high for 10 clk -> ev_cnt increments by exactly 1.
